// File: rtl/sram_pkg.sv
// Shared SRAM arbitration constants and the arbiter state encoding.
// Parameters only; no latency or backpressure of its own.
package sram_pkg;

    localparam int ADDR_W    = 18;
    localparam int DATA_W    = 16;
    localparam int V_VISIBLE = 480;
    localparam int V_RECLAIM = 524;

    typedef enum logic [1:0] {
        DISPLAY = 2'd0,
        DRAIN_W = 2'd1,
        WRITE   = 2'd2,
        DRAIN_D = 2'd3
    } arb_state_t;

endpackage

// File: rtl/sram_frame_arbiter.sv
// Time-division SRAM arbiter: pixel buffer owns active video, write buffer owns vblank; 1-cycle request-to-ram latency.
// Backpressure: one transaction in flight; requesters hold until their ready, and ownership only moves once the SRAM is idle.
module sram_frame_arbiter
    import sram_pkg::*;
#(
    parameter int ADDR_W    = sram_pkg::ADDR_W,
    parameter int DATA_W    = sram_pkg::DATA_W,
    parameter int V_VISIBLE = sram_pkg::V_VISIBLE,
    parameter int V_RECLAIM = sram_pkg::V_RECLAIM
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       hcounter,
    input  logic [9:0]        vcounter,
    input  logic [ADDR_W-1:0] pb_address,
    input  logic              pb_read,
    output logic              pb_ready,
    input  logic [ADDR_W-1:0] wb_address,
    input  logic              wb_read,
    input  logic              wb_write,
    input  logic [DATA_W-1:0] wb_data_write,
    input  logic              wb_done,
    output logic              wb_ready,
    output logic              wb_start,
    output logic              wb_clk_en,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_data_write,
    input  logic              ram_ready,
    output logic [7:0]        overrun_count
);

    arb_state_t        state_q, state_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic              ram_read_q, ram_read_d;
    logic              ram_write_q, ram_write_d;
    logic [DATA_W-1:0] ram_data_write_q, ram_data_write_d;
    logic              wb_start_q, wb_start_d;
    logic              wb_clk_en_q, wb_clk_en_d;
    logic [7:0]        overrun_count_q, overrun_count_d;

    logic              win_open, win_close, drained, issue;
    logic              req_rd, req_wr;
    logic [ADDR_W-1:0] req_addr;

    assign win_open  = (vcounter == 10'(V_VISIBLE)) && (hcounter == '0);
    assign win_close = (vcounter == 10'(V_RECLAIM)) && (hcounter == '0);
    // The cycle ram_ready arrives already counts as idle for handover.
    assign drained   = !busy_q || ram_ready;

    always_comb begin
        req_rd   = 1'b0;
        req_wr   = 1'b0;
        req_addr = pb_address;
        case (state_q)
            DISPLAY: req_rd = pb_read;
            WRITE: begin
                req_rd   = wb_read & ~wb_write;
                req_wr   = wb_write;
                req_addr = wb_address;
            end
            default: ;
        endcase
    end

    // A requester is still holding its request on the ready cycle, so a new
    // issue waits until busy has actually cleared.
    assign issue = (req_rd | req_wr) & ~busy_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            DISPLAY: if (win_open) state_d = (drained && !issue) ? WRITE : DRAIN_W;
            DRAIN_W: if (drained) state_d = WRITE;
            WRITE:   if (win_close) state_d = DRAIN_D;
            DRAIN_D: if (drained) state_d = DISPLAY;
            default: state_d = DISPLAY;
        endcase
    end

    always_comb begin
        busy_d           = busy_q;
        ram_address_d    = ram_address_q;
        ram_data_write_d = ram_data_write_q;
        ram_read_d       = ram_read_q & busy_q & ~ram_ready;
        ram_write_d      = ram_write_q & busy_q & ~ram_ready;
        if (issue) begin
            busy_d        = 1'b1;
            ram_address_d = req_addr;
            ram_read_d    = req_rd;
            ram_write_d   = req_wr;
            if (req_wr) ram_data_write_d = wb_data_write;
        end else if (ram_ready) begin
            busy_d = 1'b0;
        end

        wb_clk_en_d = (state_d == WRITE) || (state_d == DRAIN_D);
        wb_start_d  = (state_d == WRITE) && (state_q != WRITE);

        overrun_count_d = overrun_count_q;
        if (state_q == WRITE && win_close && !wb_done && overrun_count_q != 8'hFF)
            overrun_count_d = overrun_count_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= DISPLAY;
            busy_q           <= 1'b0;
            ram_address_q    <= '0;
            ram_read_q       <= 1'b0;
            ram_write_q      <= 1'b0;
            ram_data_write_q <= '0;
            wb_start_q       <= 1'b0;
            wb_clk_en_q      <= 1'b0;
            overrun_count_q  <= '0;
        end else begin
            state_q          <= state_d;
            busy_q           <= busy_d;
            ram_address_q    <= ram_address_d;
            ram_read_q       <= ram_read_d;
            ram_write_q      <= ram_write_d;
            ram_data_write_q <= ram_data_write_d;
            wb_start_q       <= wb_start_d;
            wb_clk_en_q      <= wb_clk_en_d;
            overrun_count_q  <= overrun_count_d;
        end
    end

    assign pb_ready       = ram_ready && (state_q == DISPLAY || state_q == DRAIN_W);
    assign wb_ready       = ram_ready && (state_q == WRITE || state_q == DRAIN_D);
    assign ram_address    = ram_address_q;
    assign ram_read       = ram_read_q;
    assign ram_write      = ram_write_q;
    assign ram_data_write = ram_data_write_q;
    assign wb_start       = wb_start_q;
    assign wb_clk_en      = wb_clk_en_q;
    assign overrun_count  = overrun_count_q;

endmodule

// File: tb/tb_sram_frame_arbiter.sv
// Directed frame-boundary scenarios followed by a randomized run against requester/SRAM models.
module tb_sram_frame_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcounter;
    logic [9:0]  vcounter;
    logic [17:0] pb_address;
    logic        pb_read;
    logic        pb_ready;
    logic [17:0] wb_address;
    logic        wb_read;
    logic        wb_write;
    logic [15:0] wb_data_write;
    logic        wb_done;
    logic        wb_ready;
    logic        wb_start;
    logic        wb_clk_en;
    logic [17:0] ram_address;
    logic        ram_read;
    logic        ram_write;
    logic [15:0] ram_data_write;
    logic        ram_ready;
    logic [7:0]  overrun_count;

    int checks = 0;
    int failures = 0;

    sram_frame_arbiter dut (
        .clk(clk), .reset(reset), .hcounter(hcounter), .vcounter(vcounter),
        .pb_address(pb_address), .pb_read(pb_read), .pb_ready(pb_ready),
        .wb_address(wb_address), .wb_read(wb_read), .wb_write(wb_write),
        .wb_data_write(wb_data_write), .wb_done(wb_done), .wb_ready(wb_ready),
        .wb_start(wb_start), .wb_clk_en(wb_clk_en), .ram_address(ram_address),
        .ram_read(ram_read), .ram_write(ram_write), .ram_data_write(ram_data_write),
        .ram_ready(ram_ready), .overrun_count(overrun_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Randomized-phase model state
    localparam int H_TOT = 4;
    localparam int V_TOT = 525;
    localparam int RUN   = 5 * H_TOT * V_TOT;
    localparam int DRAIN_MAX = 6000;

    logic        pb_act, pb_served, pb_got;
    logic [17:0] pb_addr_x;
    logic        wb_act, wb_served, wb_got, wb_wr_x;
    logic [17:0] wb_addr_x;
    logic [15:0] wb_data_x;
    logic        s_busy, s_owner_wb;
    int          s_lat;
    int          pb_issued, pb_completed, wb_issued, wb_completed;
    int          ovr_exp, trig_cnt, start_cnt, pb_pulses, h, v, wtype;
    logic        m_pb, m_wb, stop, idle;

    initial begin
        reset = 1'b1; hcounter = '0; vcounter = '0;
        pb_address = '0; pb_read = 1'b0;
        wb_address = '0; wb_read = 1'b0; wb_write = 1'b0; wb_data_write = '0;
        wb_done = 1'b1; ram_ready = 1'b0;
        repeat (8) tick();

        check("rst_addr", 32'(ram_address), 0);
        check("rst_rd", 32'(ram_read), 0);
        check("rst_wr", 32'(ram_write), 0);
        check("rst_data", 32'(ram_data_write), 0);
        check("rst_start", 32'(wb_start), 0);
        check("rst_clken", 32'(wb_clk_en), 0);
        check("rst_ovr", 32'(overrun_count), 0);
        ram_ready = 1'b1; #1;
        check("rst_pb_owner", 32'(pb_ready), 1);
        check("rst_wb_owner", 32'(wb_ready), 0);
        ram_ready = 1'b0;

        // Release and first display read
        reset = 1'b0; pb_address = 18'h00123; pb_read = 1'b1;
        tick();
        check("t1_addr", 32'(ram_address), 32'h123);
        check("t1_rd", 32'(ram_read), 1);
        check("t1_wr", 32'(ram_write), 0);
        ram_ready = 1'b1; #1;
        check("t1_pbrdy", 32'(pb_ready), 1);
        tick();
        pb_read = 1'b0; ram_ready = 1'b0;
        check("t1_rd_drop", 32'(ram_read), 0);

        // Window opens with SRAM idle
        vcounter = 10'd480; hcounter = 11'd0;
        tick();
        check("t2_start", 32'(wb_start), 1);
        check("t2_clken", 32'(wb_clk_en), 1);
        hcounter = 11'd1; wb_address = 18'h3FFFF; wb_write = 1'b1; wb_data_write = 16'hFFFF;
        tick();
        check("t2_start_once", 32'(wb_start), 0);
        check("t2_addr", 32'(ram_address), 32'h3FFFF);
        check("t2_wr", 32'(ram_write), 1);
        check("t2_rd", 32'(ram_read), 0);
        check("t2_data", 32'(ram_data_write), 32'hFFFF);
        ram_ready = 1'b1; #1;
        check("t2_wbrdy", 32'(wb_ready), 1);
        check("t2_pbrdy", 32'(pb_ready), 0);
        tick();
        wb_write = 1'b0; ram_ready = 1'b0;

        // Read and write together: write wins
        wb_address = 18'h00055; wb_read = 1'b1; wb_write = 1'b1; wb_data_write = 16'h1234;
        tick();
        check("t6_wr", 32'(ram_write), 1);
        check("t6_rd", 32'(ram_read), 0);
        check("t6_addr", 32'(ram_address), 32'h55);
        ram_ready = 1'b1;
        tick();
        wb_read = 1'b0; wb_write = 1'b0; ram_ready = 1'b0;
        tick();

        // Write outstanding at reclaim
        wb_address = 18'h00777; wb_write = 1'b1; wb_data_write = 16'hABCD;
        tick();
        vcounter = 10'd524; hcounter = 11'd0;
        tick();
        hcounter = 11'd1;
        check("t4_clken", 32'(wb_clk_en), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_hold_clken", 32'(wb_clk_en), 1);
            check("t4_hold_wr", 32'(ram_write), 1);
        end
        ram_ready = 1'b1; #1;
        check("t4_wbrdy", 32'(wb_ready), 1);
        tick();
        check("t4_clken_drop", 32'(wb_clk_en), 0);
        check("t4_ovr", 32'(overrun_count), 0);
        ram_ready = 1'b0;
        // Follow-up request made during the drain must wait for next window
        wb_address = 18'h0BEEF; wb_write = 1'b1; wb_data_write = 16'h5A5A;
        vcounter = 10'd0; hcounter = 11'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_blocked", 32'(ram_write), 0);
        end
        vcounter = 10'd480; hcounter = 11'd0;
        tick();
        check("t4_start", 32'(wb_start), 1);
        hcounter = 11'd1;
        tick();
        check("t4_reissue_addr", 32'(ram_address), 32'h0BEEF);
        check("t4_reissue_wr", 32'(ram_write), 1);
        ram_ready = 1'b1;
        tick();
        wb_write = 1'b0; ram_ready = 1'b0;

        // Back to display, then a read held across the window trigger
        vcounter = 10'd524; hcounter = 11'd0;
        tick();
        hcounter = 11'd1;
        tick();
        vcounter = 10'd0; hcounter = 11'd0;
        tick();
        pb_address = 18'h00200; pb_read = 1'b1;
        tick();
        check("t3_rd", 32'(ram_read), 1);
        vcounter = 10'd480; hcounter = 11'd0;
        pb_pulses = 0;
        tick();
        hcounter = 11'd1;
        for (int i = 0; i < 4; i++) begin
            check("t3_nostart", 32'(wb_start), 0);
            check("t3_noclk", 32'(wb_clk_en), 0);
            if (pb_ready) pb_pulses++;
            tick();
        end
        ram_ready = 1'b1; #1;
        if (pb_ready) pb_pulses++;
        tick();
        check("t3_start", 32'(wb_start), 1);
        ram_ready = 1'b0; pb_read = 1'b0; #1;
        if (pb_ready) pb_pulses++;
        tick();
        check("t3_start_once", 32'(wb_start), 0);
        check("t3_pb_pulses", 32'(pb_pulses), 1);

        // Overruns: three, then force saturation
        wb_done = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            vcounter = 10'd524; hcounter = 11'd0;
            tick();
            hcounter = 11'd1;
            tick();
            vcounter = 10'd480; hcounter = 11'd0;
            tick();
            hcounter = 11'd1;
            if (i == 3)   check("t5_ovr3", 32'(overrun_count), 3);
            if (i == 254) check("t5_ovr254", 32'(overrun_count), 254);
        end
        check("t5_sat", 32'(overrun_count), 255);

        // Reset with a write in flight
        wb_address = 18'h00321; wb_write = 1'b1; wb_data_write = 16'h7777;
        tick();
        check("rst2_pre_wr", 32'(ram_write), 1);
        reset = 1'b1;
        tick();
        check("rst2_wr", 32'(ram_write), 0);
        check("rst2_addr", 32'(ram_address), 0);
        check("rst2_clken", 32'(wb_clk_en), 0);
        check("rst2_ovr", 32'(overrun_count), 0);
        reset = 1'b0; wb_write = 1'b0; wb_done = 1'b1;
        vcounter = 10'd0; hcounter = 11'd0;

        // Randomized run
        pb_act = 0; pb_served = 0; pb_got = 0; wb_act = 0; wb_served = 0; wb_got = 0;
        pb_addr_x = '0; wb_addr_x = '0; wb_data_x = '0; wb_wr_x = 0;
        s_busy = 0; s_owner_wb = 0; s_lat = 0;
        pb_issued = 0; pb_completed = 0; wb_issued = 0; wb_completed = 0;
        ovr_exp = 0; trig_cnt = 0; start_cnt = 0; h = 0; v = 0; idle = 0;
        for (int cyc = 0; cyc < RUN + DRAIN_MAX; cyc++) begin
            tick();
            stop = (cyc >= RUN);
            check("rand_rw_excl", 32'(ram_read & ram_write), 0);
            if (wb_start) start_cnt++;
            if (!s_busy && (ram_read || ram_write)) begin
                m_pb = pb_act && !pb_served && ram_read && !ram_write && ram_address == pb_addr_x;
                m_wb = wb_act && !wb_served && ram_write == wb_wr_x && ram_read == !wb_wr_x &&
                       ram_address == wb_addr_x && (!wb_wr_x || ram_data_write == wb_data_x);
                check("rand_txn_match", 32'(m_pb | m_wb), 1);
                if (m_wb) check("rand_wb_enabled", 32'(wb_clk_en), 1);
                if (m_pb) pb_served = 1;
                if (m_wb) wb_served = 1;
                s_busy = 1; s_owner_wb = m_wb; s_lat = $urandom_range(0, 3);
            end
            if (pb_got) begin pb_act = 0; pb_completed++; end
            if (wb_got) begin wb_act = 0; wb_completed++; end
            if (!pb_act && !stop && $urandom_range(0, 3) == 0) begin
                pb_act = 1; pb_served = 0; pb_issued++;
                pb_addr_x = {1'b0, 17'($urandom)};
            end
            if (!wb_act && wb_clk_en && !stop && $urandom_range(0, 2) == 0) begin
                wb_act = 1; wb_served = 0; wb_issued++;
                wtype = $urandom_range(0, 2);
                wb_wr_x = (wtype != 0);
                wb_addr_x = {1'b1, 17'($urandom)};
                wb_data_x = 16'($urandom);
                wb_read = (wtype != 1);
                wb_write = wb_wr_x;
            end
            pb_read = pb_act; pb_address = pb_addr_x;
            if (!wb_act) begin wb_read = 1'b0; wb_write = 1'b0; end
            wb_address = wb_addr_x; wb_data_write = wb_data_x;
            hcounter = 11'(h); vcounter = 10'(v);
            if (v == 480 && h == 0) begin
                trig_cnt++;
                wb_done = 1'($urandom_range(0, 1));
            end
            if (v == 524 && h == 0 && !wb_done && ovr_exp < 255) ovr_exp++;
            ram_ready = 1'b0;
            if (s_busy) begin
                if (s_lat == 0) ram_ready = 1'b1;
                else s_lat--;
            end
            #1;
            pb_got = pb_ready; wb_got = wb_ready;
            if (ram_ready) begin
                check("rand_pb_route", 32'(pb_ready), 32'(!s_owner_wb));
                check("rand_wb_route", 32'(wb_ready), 32'(s_owner_wb));
                s_busy = 0;
            end else begin
                check("rand_no_ready", 32'(pb_ready | wb_ready), 0);
            end
            h++;
            if (h == H_TOT) begin
                h = 0; v++;
                if (v == V_TOT) v = 0;
            end
            idle = !pb_act && !wb_act && !s_busy && !pb_got && !wb_got;
            if (stop && idle && v < 470 && v > 10) break;
        end
        check("rand_drained", 32'(idle), 1);
        check("rand_pb_done", 32'(pb_completed), 32'(pb_issued));
        check("rand_wb_done", 32'(wb_completed), 32'(wb_issued));
        check("rand_starts", 32'(start_cnt), 32'(trig_cnt));
        check("rand_overruns", 32'(overrun_count), 32'(ovr_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_frame_arbiter.md
# sram_frame_arbiter

Time-division arbiter sharing the single `sram` controller between `pixel_buffer` (display reads) and `write_buffer` (camera draw/erase). It replaces the ad-hoc vcounter mux. The pixel buffer owns the SRAM during active video; the write buffer owns it during vertical blanking. Ownership changes only at transaction boundaries, and the write buffer's clock enable and start pulse are gated so neither requester ever loses a transaction.

## Interface
- `ADDR_W`, 18: SRAM word address width.
- `DATA_W`, 16: SRAM data width.
- `V_VISIBLE`, 480: first blanking line; the write window opens here.
- `V_RECLAIM`, 524: line on which the display reclaims the SRAM, so the pixel buffer can prefetch line 0.
- `clk`  in  1  pixel clock, the same clock as `vga` and `sram`.
- `reset`  in  1  synchronous, active-high.
- `hcounter`  in  11  from `vga`.
- `vcounter`  in  10  from `vga`.
- `pb_address`  in  ADDR_W  pixel buffer address.
- `pb_read`  in  1  pixel buffer read request (level).
- `pb_ready`  out  1  `ram_ready` routed to the pixel buffer.
- `wb_address`  in  ADDR_W  write buffer address.
- `wb_read`  in  1  write buffer read request (level).
- `wb_write`  in  1  write buffer write request (level).
- `wb_data_write`  in  DATA_W  write buffer write data.
- `wb_done`  in  1  write buffer has finished its frame's work.
- `wb_ready`  out  1  `ram_ready` routed to the write buffer.
- `wb_start`  out  1  one-cycle pulse that opens the write window.
- `wb_clk_en`  out  1  clock enable for the write buffer.
- `ram_address`  out  ADDR_W  to `sram.address`.
- `ram_read`  out  1  to `sram.read`.
- `ram_write`  out  1  to `sram.write`.
- `ram_data_write`  out  DATA_W  to `sram.data_write`.
- `ram_ready`  in  1  from `sram.ready`.
- `overrun_count`  out  8  saturating count of windows closed with `wb_done` low.

## Operation
- Requesters hold read/write, address and data stable until they see their ready.
- A transaction is outstanding from a forwarded request until `ram_ready` is high.
- The `busy` flag is set on a forwarded request and cleared by `ram_ready`.

States:
- DISPLAY: forward `pb_*`; `wb_clk_en`=0. On `vcounter==V_VISIBLE && hcounter==0`, go to DRAIN_W.
- DRAIN_W: block new `pb` requests. Once `busy`=0, go to WRITE.
- WRITE: pulse `wb_start` for exactly one cycle on entry; `wb_clk_en`=1; forward `wb_*`. On `vcounter==V_RECLAIM && hcounter==0`, go to DRAIN_D.
- DRAIN_D: block new `wb` requests; keep `wb_clk_en`=1. On the cycle `busy` clears, drop `wb_clk_en` and go to DISPLAY.
  - A request the write buffer made during the drain stays held and is served next frame.

Other rules:
- Overrun: when entering DRAIN_D with `wb_done`=0, `overrun_count` increments and saturates at 255.
- Ready routing: `pb_ready = ram_ready & (state==DISPLAY|DRAIN_W)`; `wb_ready = ram_ready & (state==WRITE|DRAIN_D)`.
- `ram_read` and `ram_write` are never both 1. If the write buffer asserts both, write wins.
- Reset mid-operation: the SRAM controller is reset on the same `reset`, so any in-flight transaction is abandoned.

## Timing
- All `ram_*` outputs, `wb_start`, `wb_clk_en` and `overrun_count` are registered. Latency is one cycle from requester inputs to `ram_*`.
- `pb_ready` and `wb_ready` are combinational from `ram_ready` and the registered state.
- Reset values:
  - state DISPLAY, `busy`=0;
  - `ram_address`=0, `ram_read`=0, `ram_write`=0, `ram_data_write`=0;
  - `wb_start`=0, `wb_clk_en`=0, `overrun_count`=0.
- With `ram_ready` high, `wb_start` is high exactly on the cycle after the trigger `vcounter=480, hcounter=0` is sampled.
- A drain extends until `ram_ready`; there is no timeout. A window trigger that arrives while draining is ignored.
- `hcounter` and `vcounter` are compared as unsigned values. Triggers are edge-free equality matches and fire once per frame.

## Structure
- Shared package `sram_pkg`: `ADDR_W`, `DATA_W`, `V_VISIBLE`, `V_RECLAIM`, and the state enum `arb_state_t` (DISPLAY, DRAIN_W, WRITE, DRAIN_D).
- Single flat module; no sub-module. The saturating counter is inline.

## Test plan
- Reset held 8 cycles, then released at vcounter=0 -> all outputs 0; state DISPLAY; `pb_address`=0x00123 appears on `ram_address` one cycle later.
- Counters reach 480/0 with `busy`=0 -> one-cycle `wb_start`; `wb_clk_en`=1; `wb_address`=0x3FFFF with `wb_write`=1 and data 0xFFFF appear on `ram_*` one cycle later.
- `pb` read outstanding at 480/0 with `ram_ready` withheld 5 cycles -> `wb_start` is delayed until the cycle after `ram_ready`; `pb_ready` pulses once.
- Write outstanding at 524/0 -> `wb_clk_en` stays 1 until `ram_ready`, then drops. `wb` request held across the frame -> reissued after the next `wb_start`.
- `wb_done`=0 at three successive reclaims -> `overrun_count`=3. Force 300 overruns -> count saturates at 255.
- `wb_read`=`wb_write`=1 during WRITE -> `ram_write`=1, `ram_read`=0.
